instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
// - Inverse of the main control decoder: accepts symbolic instructions (kind + fields) over a
//   valid/ready stream, packs each into a 32-bit MIPS word, writes it to instruction memory.
// - Used by the bench/boot path to load programs into IM before the CPU leaves reset.
// - The opcode map is identical to the decoder's, so every word emitted decodes back to its kind.
// PARAMETERS
// - ADDR_W     32   width of IM byte address
// - MAX_WORDS  256  capacity; words beyond it are rejected
// PORTS
// - clk_i        in   1      clock, rising edge
// - rst_i        in   1      asynchronous, active-low reset
// - start_i      in   1      1-cycle pulse: begin load session at base_addr_i (IDLE/DONE only)
// - base_addr_i  in   ADDR_W first word address; must be word-aligned, low 2 bits ignored
// - end_i        in   1      1-cycle pulse: close session once pending write completes
// - op_valid_i   in   1      instruction fields valid
// - op_ready_o   out  1      encoder can take an instruction this cycle
// - op_kind_i    in   4      R=0 ADDI=1 BEQ=2 BNE=3 ORI=4 LUI=5 LW=6 SW=7 J=8 JAL=9 BLE=10 BLT=11
// - rs_i/rt_i/rd_i/shamt_i  in 5 each; funct_i in 6; imm_i in 16; target_i in 26
// - im_we_o      out  1      IM write request, held until im_ack_i
// - im_addr_o    out  ADDR_W IM byte address
// - im_wdata_o   out  32     encoded instruction word
// - im_ack_i     in   1      IM accepted write this cycle (may be same cycle as im_we_o)
// - count_o      out  ADDR_W words written this session
// - busy_o / done_o / err_o  out 1 each: session active / session closed / sticky error
// BEHAVIOUR
// - Reset: state IDLE; op_ready_o, im_we_o, busy_o, done_o, err_o = 0; im_addr_o, im_wdata_o,
//   count_o = 0. Reset mid-write drops the write with no completion.
// - FSM IDLE -start_i-> ACCEPT; ACCEPT -valid&ready, legal kind-> WRITE; WRITE -im_ack_i-> ACCEPT;
//   ACCEPT -end_i-> DONE; WRITE with end_i seen -> DONE after ack; DONE -start_i-> ACCEPT (new session).
// - start_i clears count_o, err_o, done_o and loads im_addr_o = {base_addr_i[ADDR_W-1:2],2'b00}.
// - op_ready_o = 1 only in ACCEPT and count_o < MAX_WORDS; handshake completes when valid&ready.
// - Encoding (registered; im_wdata_o valid the cycle im_we_o rises, i.e. 1 cycle after handshake):
//   R: {6'h00,rs,rt,rd,shamt,funct}; ADDI 6'h08, BEQ 6'h04, BNE 6'h05, ORI 6'h0d, LW 6'h23,
//   SW 6'h2b, BLE 6'h07, BLT 6'h06: {op,rs,rt,imm}; LUI: {6'h0f,5'd0,rt,imm};
//   J: {6'h02,target}; JAL: {6'h03,target}.
// - Illegal kind (12..15): consumed (ready held), no write, err_o set sticky, count unchanged.
// - On im_ack_i: count_o += 1, im_addr_o += 4 (wraps modulo 2^ADDR_W), im_we_o drops same edge.
// - Full: count_o == MAX_WORDS -> op_ready_o = 0; valid held there sets err_o, no write.
// - end_i and a handshake in the same cycle: the instruction is written, then DONE.
// - start_i outside IDLE/DONE and end_i outside a session are ignored.
// - done_o = 1 in DONE only; busy_o = 1 in ACCEPT/WRITE.
// STRUCTURE
// - Shared package (also imported by the decoder): op_kind enum, 6-bit opcode constants
//   OP_RTYPE..OP_BLT, ADDR_W default.
// - One sub-module: instr_word_pack (combinational kind+fields -> {legal, word[31:0]}),
//   instantiated once; FSM, address/count registers and IM handshake stay in this module.
// TESTING
// - start base=0x100; R rs=1 rt=2 rd=3 funct=0x20 -> wdata 0x00221820 at 0x100, count 1.
// - ADDI rs=0 rt=8 imm=0xFFFF then J target=0x40 -> 0x2008FFFF @0x100, 0x08000040 @0x104.
// - im_ack_i delayed 3 cycles -> im_we_o/addr/wdata stable 4 cycles, op_ready_o low meanwhile.
// - kind=14 -> no im_we_o, err_o=1, count unchanged; next LUI rt=1 imm=0x1234 -> 0x3C011234.
// - MAX_WORDS=2: third op -> op_ready_o=0, err_o=1; end_i -> done_o=1, count_o=2.
// - rst_i low while im_we_o=1 -> next cycle all outputs 0, state IDLE, no ack counted.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader and the control decoder:
// instruction kinds, MIPS opcode constants and loader state encoding.
package instr_encoder_loader_pkg;

    localparam int ADDR_W_DEFAULT    = 32;
    localparam int MAX_WORDS_DEFAULT = 256;

    // Symbolic instruction kinds as presented on the op stream
    typedef enum logic [3:0] {
        KIND_R    = 4'd0,
        KIND_ADDI = 4'd1,
        KIND_BEQ  = 4'd2,
        KIND_BNE  = 4'd3,
        KIND_ORI  = 4'd4,
        KIND_LUI  = 4'd5,
        KIND_LW   = 4'd6,
        KIND_SW   = 4'd7,
        KIND_J    = 4'd8,
        KIND_JAL  = 4'd9,
        KIND_BLE  = 4'd10,
        KIND_BLT  = 4'd11
    } op_kind_e;

    // Primary opcode field values, identical to the decoder's map
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BLE   = 6'h07;
    localparam logic [5:0] OP_BLT   = 6'h06;

    // Loader session states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } load_state_e;

    // Opcode for a kind; kinds outside the map return all-ones (never emitted)
    function automatic logic [5:0] kind_opcode(input logic [3:0] kind);
        logic [5:0] opc;
        case (kind)
            KIND_R:    opc = OP_RTYPE;
            KIND_ADDI: opc = OP_ADDI;
            KIND_BEQ:  opc = OP_BEQ;
            KIND_BNE:  opc = OP_BNE;
            KIND_ORI:  opc = OP_ORI;
            KIND_LUI:  opc = OP_LUI;
            KIND_LW:   opc = OP_LW;
            KIND_SW:   opc = OP_SW;
            KIND_J:    opc = OP_J;
            KIND_JAL:  opc = OP_JAL;
            KIND_BLE:  opc = OP_BLE;
            KIND_BLT:  opc = OP_BLT;
            default:   opc = 6'h3f;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_word_pack.sv
// Combinational packer: instruction kind plus fields -> 32-bit MIPS word.
// Kinds outside the opcode map report legal = 0 and a zero word.
module instr_word_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        legal,
    output logic [31:0] word
);

    // Select the field layout for the kind: R, I (with LUI's zero rs) or J
    always_comb begin
        legal = 1'b1;
        word  = 32'd0;
        case (kind)
            KIND_R:
                word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_ADDI, KIND_BEQ, KIND_BNE, KIND_ORI,
            KIND_LW, KIND_SW, KIND_BLE, KIND_BLT:
                word = {kind_opcode(kind), rs, rt, imm};
            KIND_LUI:
                word = {OP_LUI, 5'd0, rt, imm};
            KIND_J:
                word = {OP_J, target};
            KIND_JAL:
                word = {OP_JAL, target};
            default:
                legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot-path program loader: takes symbolic instructions over a valid/ready
// stream, encodes each into a MIPS word and writes it to instruction memory
// at consecutive word addresses, one outstanding write at a time.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              end_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [3:0]        op_kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    input  logic              im_ack_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_WORDS);

    load_state_e       state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] count_reg;
    logic [31:0]       wdata_reg;
    logic              we_reg;
    logic              ready_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic              end_pending_reg;

    logic              pack_legal;
    logic [31:0]       pack_word;
    logic              handshake;
    logic              full;
    logic [ADDR_W-1:0] count_next;

    // Word alignment is forced, so the byte-offset bits of the base never matter
    logic unused_base_bits;
    assign unused_base_bits = ^base_addr_i[1:0];

    instr_word_pack u_pack (
        .kind   (op_kind_i),
        .rs     (rs_i),
        .rt     (rt_i),
        .rd     (rd_i),
        .shamt  (shamt_i),
        .funct  (funct_i),
        .imm    (imm_i),
        .target (target_i),
        .legal  (pack_legal),
        .word   (pack_word)
    );

    assign handshake  = op_valid_i & ready_reg;
    assign full       = (count_reg >= MAX_CNT);
    assign count_next = count_reg + ADDR_W'(1);

    // Session FSM with address/count bookkeeping and the IM write handshake
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            count_reg       <= '0;
            wdata_reg       <= '0;
            we_reg          <= 1'b0;
            ready_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            end_pending_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    // end_i has no meaning outside a session
                    if (start_i) begin
                        state_reg       <= ST_ACCEPT;
                        addr_reg        <= {base_addr_i[ADDR_W-1:2], 2'b00};
                        count_reg       <= '0;
                        err_reg         <= 1'b0;
                        done_reg        <= 1'b0;
                        busy_reg        <= 1'b1;
                        ready_reg       <= (MAX_CNT != '0);
                        end_pending_reg <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    if (handshake && pack_legal) begin
                        // Encoded word and write request appear together next cycle
                        state_reg       <= ST_WRITE;
                        we_reg          <= 1'b1;
                        wdata_reg       <= pack_word;
                        ready_reg       <= 1'b0;
                        end_pending_reg <= end_i;
                    end else begin
                        // Illegal kind is swallowed; a valid op against a full
                        // buffer is refused. Both are reported through err.
                        if (handshake || (op_valid_i && full)) begin
                            err_reg <= 1'b1;
                        end
                        if (end_i) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            ready_reg <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (im_ack_i) begin
                        we_reg    <= 1'b0;
                        count_reg <= count_next;
                        addr_reg  <= addr_reg + ADDR_W'(4);
                        if (end_pending_reg || end_i) begin
                            state_reg       <= ST_DONE;
                            done_reg        <= 1'b1;
                            busy_reg        <= 1'b0;
                            end_pending_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_ACCEPT;
                            ready_reg <= (count_next < MAX_CNT);
                        end
                    end else if (end_i) begin
                        end_pending_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_ready_o = ready_reg;
    assign im_we_o    = we_reg;
    assign im_addr_o  = addr_reg;
    assign im_wdata_o = wdata_reg;
    assign count_o    = count_reg;
    assign busy_o     = busy_reg;
    assign done_o     = done_reg;
    assign err_o      = err_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios followed by
// randomized sessions, checked against a field-arithmetic reference model.
module tb_instr_encoder_loader;

    localparam int MAXW = 2;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic        end_i;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [3:0]  op_kind_i;
    logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic [25:0] target_i;
    logic        im_we_o;
    logic [31:0] im_addr_o;
    logic [31:0] im_wdata_o;
    logic        im_ack_i;
    logic [31:0] count_o;
    logic        busy_o, done_o, err_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_addr;
    int          m_count;
    bit          m_err, m_done, m_busy;

    instr_encoder_loader #(.ADDR_W(32), .MAX_WORDS(MAXW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .end_i       (end_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .op_kind_i   (op_kind_i),
        .rs_i        (rs_i),
        .rt_i        (rt_i),
        .rd_i        (rd_i),
        .shamt_i     (shamt_i),
        .funct_i     (funct_i),
        .imm_i       (imm_i),
        .target_i    (target_i),
        .im_we_o     (im_we_o),
        .im_addr_o   (im_addr_o),
        .im_wdata_o  (im_wdata_o),
        .im_ack_i    (im_ack_i),
        .count_o     (count_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference encoding from the MIPS field layout, by place-value arithmetic.
    // Bit 32 of the result is the legal flag.
    function automatic logic [32:0] ref_encode(input int kind, input int rs, input int rt,
                                               input int rd, input int shamt, input int funct,
                                               input int imm, input int target);
        int     opc [12];
        longint w;
        opc = '{0, 8, 4, 5, 13, 15, 35, 43, 2, 3, 7, 6};
        if (kind < 0 || kind > 11) return 33'd0;
        if (kind == 0)
            w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
              + longint'(shamt) * 64 + longint'(funct);
        else if (kind == 8 || kind == 9)
            w = longint'(opc[kind]) * 67108864 + longint'(target);
        else if (kind == 5)
            w = longint'(opc[kind]) * 67108864 + longint'(rt) * 65536 + longint'(imm);
        else
            w = longint'(opc[kind]) * 67108864 + longint'(rs) * 2097152
              + longint'(rt) * 65536 + longint'(imm);
        return {1'b1, w[31:0]};
    endfunction

    task automatic check_status(input string tag);
        check({tag, "_count"}, count_o, 32'(m_count));
        check({tag, "_err"},   32'(err_o),  32'(m_err));
        check({tag, "_done"},  32'(done_o), 32'(m_done));
        check({tag, "_busy"},  32'(busy_o), 32'(m_busy));
    endtask

    // Open a session; caller is at a falling edge
    task automatic start_sess(input logic [31:0] base);
        start_i = 1'b1;
        base_addr_i = base;
        @(negedge clk_i);
        start_i = 1'b0;
        m_addr = {base[31:2], 2'b00};
        m_count = 0; m_err = 0; m_done = 0; m_busy = 1;
        $display("start base=0x%08h", base);
        check("start_addr", im_addr_o, m_addr);
        check("start_ready", 32'(op_ready_o), 32'd1);
        check_status("start");
    endtask

    task automatic end_sess();
        end_i = 1'b1;
        @(negedge clk_i);
        end_i = 1'b0;
        if (m_busy) begin
            m_busy = 0; m_done = 1;
        end
        $display("end count=%0d", m_count);
        check("end_ready", 32'(op_ready_o), 32'd0);
        check_status("end");
    endtask

    // Present one instruction, acknowledge its write after dly cycles
    task automatic do_op(input int kind, input int rs, input int rt, input int rd,
                         input int shamt, input int funct, input int imm, input int target,
                         input int dly, input bit with_end);
        logic [32:0] r;
        r = ref_encode(kind, rs, rt, rd, shamt, funct, imm, target);
        op_kind_i = 4'(kind); rs_i = 5'(rs); rt_i = 5'(rt); rd_i = 5'(rd);
        shamt_i = 5'(shamt); funct_i = 6'(funct); imm_i = 16'(imm); target_i = 26'(target);
        op_valid_i = 1'b1;
        end_i = with_end;
        check("op_ready", 32'(op_ready_o), 32'(m_busy && m_count < MAXW));
        @(negedge clk_i);
        op_valid_i = 1'b0;
        end_i = 1'b0;
        if (m_count >= MAXW || !r[32]) begin
            m_err = 1;
            if (with_end) begin m_busy = 0; m_done = 1; end
            $display("op kind=%0d refused (full=%0d)", kind, m_count >= MAXW);
            check("rej_we", 32'(im_we_o), 32'd0);
            check("rej_ready", 32'(op_ready_o), 32'(m_busy && m_count < MAXW));
            check_status("rej");
            return;
        end
        $display("op kind=%0d addr=0x%08h word=0x%08h ackdly=%0d end=%0d",
                 kind, m_addr, r[31:0], dly, with_end);
        check("wr_we", 32'(im_we_o), 32'd1);
        check("wr_addr", im_addr_o, m_addr);
        check("wr_data", im_wdata_o, r[31:0]);
        check("wr_ready", 32'(op_ready_o), 32'd0);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk_i);
            check("hold_we", 32'(im_we_o), 32'd1);
            check("hold_addr", im_addr_o, m_addr);
            check("hold_data", im_wdata_o, r[31:0]);
            check("hold_ready", 32'(op_ready_o), 32'd0);
        end
        im_ack_i = 1'b1;
        @(negedge clk_i);
        im_ack_i = 1'b0;
        m_count++;
        m_addr = m_addr + 32'd4;
        if (with_end) begin m_busy = 0; m_done = 1; end
        check("ack_we", 32'(im_we_o), 32'd0);
        check("ack_addr", im_addr_o, m_addr);
        check("ack_ready", 32'(op_ready_o), 32'(m_busy && m_count < MAXW));
        check_status("ack");
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; base_addr_i = '0; end_i = 1'b0;
        op_valid_i = 1'b0; op_kind_i = '0; rs_i = '0; rt_i = '0; rd_i = '0;
        shamt_i = '0; funct_i = '0; imm_i = '0; target_i = '0; im_ack_i = 1'b0;
        m_addr = '0; m_count = 0; m_err = 0; m_done = 0; m_busy = 0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", 32'(op_ready_o), 32'd0);
        check("rst_we", 32'(im_we_o), 32'd0);
        check("rst_addr", im_addr_o, 32'd0);
        check("rst_wdata", im_wdata_o, 32'd0);
        check_status("rst");
        rst_i = 1'b1;
        @(negedge clk_i);

        // R-type at 0x100
        start_sess(32'h100);
        do_op(0, 1, 2, 3, 0, 32'h20, 0, 0, 0, 1'b0);
        check("r_word_const", im_wdata_o, 32'h00221820);
        end_sess();

        // ADDI then J with a 3-cycle ack delay, end_i alongside the J handshake
        start_sess(32'h100);
        do_op(1, 0, 8, 0, 0, 0, 32'hFFFF, 0, 0, 1'b0);
        check("addi_word_const", im_wdata_o, 32'h2008FFFF);
        do_op(8, 0, 0, 0, 0, 0, 0, 32'h40, 3, 1'b1);
        check("j_word_const", im_wdata_o, 32'h08000040);

        // Illegal kind, LUI, then overflow against capacity 2
        start_sess(32'h300);
        do_op(14, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        do_op(5, 0, 1, 0, 0, 0, 32'h1234, 0, 1, 1'b0);
        check("lui_word_const", im_wdata_o, 32'h3C011234);
        do_op(4, 3, 4, 0, 0, 0, 32'h00FF, 0, 0, 1'b0);
        do_op(2, 1, 1, 0, 0, 0, 1, 0, 0, 1'b0);
        end_sess();
        check("full_count_const", count_o, 32'd2);

        // Unaligned base near the top of the address space wraps to 0
        start_sess(32'hFFFF_FFFE);
        do_op(6, 29, 31, 0, 0, 0, 32'h8000, 0, 0, 1'b0);
        start_i = 1'b1; base_addr_i = 32'h500;
        @(negedge clk_i);
        start_i = 1'b0;
        check("start_ignored_addr", im_addr_o, m_addr);
        check_status("start_ignored");
        do_op(9, 0, 0, 0, 0, 0, 0, 32'h3FF_FFFF, 2, 1'b0);
        check("wrap_addr_const", im_addr_o, 32'h4);
        end_sess();

        // Reset in the middle of an outstanding write, ack presented meanwhile
        start_sess(32'h200);
        op_kind_i = 4'd7; rs_i = 5'd2; rt_i = 5'd3; imm_i = 16'h10; op_valid_i = 1'b1;
        @(negedge clk_i);
        op_valid_i = 1'b0;
        check("pre_rst_we", 32'(im_we_o), 32'd1);
        rst_i = 1'b0; im_ack_i = 1'b1;
        @(negedge clk_i);
        m_addr = '0; m_count = 0; m_err = 0; m_done = 0; m_busy = 0;
        check("midrst_we", 32'(im_we_o), 32'd0);
        check("midrst_addr", im_addr_o, 32'd0);
        check("midrst_wdata", im_wdata_o, 32'd0);
        check("midrst_ready", 32'(op_ready_o), 32'd0);
        check_status("midrst");
        rst_i = 1'b1;
        @(negedge clk_i);
        im_ack_i = 1'b0;
        @(negedge clk_i);
        check_status("postrst");
        end_sess();

        // Randomized sessions
        for (int s = 0; s < 25; s++) begin
            int n;
            bit ended;
            start_sess($urandom);
            n = $urandom_range(0, 4);
            ended = 0;
            for (int k = 0; k < n && !ended; k++) begin
                bit e;
                e = ($urandom_range(0, 5) == 0);
                do_op($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                      $urandom_range(0, 65535), $urandom_range(0, 32'h3FF_FFFF),
                      $urandom_range(0, 3), e);
                ended = e;
            end
            if (!ended) end_sess();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
